// File: rtl/risc32_stall_ctrl_pkg.sv
// rtl/risc32_stall_ctrl_pkg.sv - shared constants and state type for the risc32 stall/flush sequencer
package risc32_stall_ctrl_pkg;

    localparam int STALL_W   = 6;
    localparam int CNT_W_DEF = 6;

    // Stall bus bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB, 1 = stop
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        SC_IDLE    = 2'd0,
        SC_MC_WAIT = 2'd1,
        SC_FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/risc32_stall_ctrl_if.sv
// rtl/risc32_stall_ctrl_if.sv - request/response bundle between the pipeline and the stall sequencer
//  master: pipeline side, drives stall/multi-cycle/flush requests, receives stall bus, flush, redirect PC
//  slave : sequencer side, the mirror image
interface risc32_stall_ctrl_if
    import risc32_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic               stallreq_id_i;
    logic               stallreq_ex_i;
    logic               mc_start_i;
    logic [CNT_W-1:0]   mc_cycles_i;
    logic               flush_req_i;
    logic [31:0]        flush_pc_i;
    logic [STALL_W-1:0] stall_o;
    logic               flush_o;
    logic [31:0]        new_pc_o;
    logic               mc_busy_o;
    logic               mc_done_o;

    modport master (
        output stallreq_id_i, stallreq_ex_i, mc_start_i, mc_cycles_i, flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
    );

    modport slave (
        input  stallreq_id_i, stallreq_ex_i, mc_start_i, mc_cycles_i, flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
    );

endinterface

// File: rtl/risc32_stall_ctrl_mc_counter.sv
// rtl/risc32_stall_ctrl_mc_counter.sv - saturating down-counter for multi-cycle EX operations
//  clk, rst      : clock, async active-high reset
//  load_i/val_i  : load a new count
//  dec_i         : decrement (ignored at zero, never wraps)
//  clr_i         : clear to zero, highest priority
//  zero_o        : current count is zero
//  next_zero_o   : count will be zero after this edge
module risc32_mc_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic             zero_o,
    output logic             next_zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o      = (cnt_q == '0);
    assign next_zero_o = (cnt_d == '0);

endmodule

// File: rtl/risc32_stall_ctrl.sv
// rtl/risc32_stall_ctrl.sv - central stall/flush sequencer for the 5-stage risc32 pipeline
//  clk, rst : clock, async active-high reset
//  bus      : slave side of risc32_stall_ctrl_if
//             in : stallreq_id_i, stallreq_ex_i, mc_start_i, mc_cycles_i, flush_req_i, flush_pc_i
//             out: stall_o (combinational), flush_o/new_pc_o/mc_done_o (registered), mc_busy_o
module risc32_stall_ctrl
    import risc32_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    risc32_stall_ctrl_if.slave    bus
);

    state_e             state_q;
    state_e             state_d;
    logic               flush_q;
    logic               flush_d;
    logic [31:0]        new_pc_q;
    logic [31:0]        new_pc_d;
    logic               mc_done_q;
    logic               mc_done_d;
    logic [STALL_W-1:0] stall_c;

    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_clr;
    logic               cnt_zero;
    logic               cnt_next_zero;
    logic               mc_req;

    // A zero-length multi-cycle op needs no extra cycles and is treated as a normal instruction.
    assign mc_req = bus.mc_start_i && (bus.mc_cycles_i != '0);

    risc32_mc_counter #(
        .CNT_W (CNT_W)
    ) u_mc_counter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (cnt_load),
        .load_val_i  (bus.mc_cycles_i - CNT_W'(1)),
        .dec_i       (cnt_dec),
        .clr_i       (cnt_clr),
        .zero_o      (cnt_zero),
        .next_zero_o (cnt_next_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SC_IDLE;
            flush_q   <= 1'b0;
            new_pc_q  <= 32'h0;
            mc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            mc_done_q <= mc_done_d;
        end
    end

    // Flush wins in every state and drops any multi-cycle op, including one starting this cycle.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            SC_IDLE: begin
                if (bus.flush_req_i) begin
                    state_d = SC_FLUSH;
                    cnt_clr = 1'b1;
                end else if (mc_req) begin
                    state_d  = SC_MC_WAIT;
                    cnt_load = 1'b1;
                end
            end
            SC_MC_WAIT: begin
                if (bus.flush_req_i) begin
                    state_d = SC_FLUSH;
                    cnt_clr = 1'b1;
                end else if (cnt_zero) begin
                    state_d = SC_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SC_FLUSH: begin
                if (bus.flush_req_i) begin
                    state_d = SC_FLUSH;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = SC_IDLE;
                end
            end
            default: begin
                state_d = SC_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        flush_d   = (state_d == SC_FLUSH);
        new_pc_d  = bus.flush_req_i ? bus.flush_pc_i : new_pc_q;
        // Done is raised for the MC_WAIT cycle whose count is zero: the last stalled cycle.
        mc_done_d = (state_d == SC_MC_WAIT) && cnt_next_zero;

        if (bus.flush_req_i || (state_q == SC_FLUSH)) begin
            stall_c = STALL_NONE;
        end else if ((state_q == SC_MC_WAIT) || bus.stallreq_ex_i ||
                     ((state_q == SC_IDLE) && mc_req)) begin
            stall_c = STALL_EX;
        end else if (bus.stallreq_id_i) begin
            stall_c = STALL_ID;
        end else begin
            stall_c = STALL_NONE;
        end
    end

    assign bus.stall_o   = stall_c;
    assign bus.flush_o   = flush_q;
    assign bus.new_pc_o  = new_pc_q;
    assign bus.mc_busy_o = (state_q == SC_MC_WAIT);
    assign bus.mc_done_o = mc_done_q;

endmodule

// File: tb/tb_risc32_stall_ctrl.sv
// tb/tb_risc32_stall_ctrl.sv - self-checking bench for risc32_stall_ctrl
module tb_risc32_stall_ctrl;

    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    risc32_stall_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    risc32_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference: remaining stalled MC_WAIT cycles, pending flush strobe, latched redirect PC.
    int          rem   = 0;
    bit          fl_now = 1'b0;
    logic [31:0] pc_m  = 32'h0;

    logic [5:0]  obs_stall;
    logic        obs_done;
    logic        obs_flush;
    logic [31:0] obs_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit id, input bit ex, input bit st, input int n,
                          input bit fr, input logic [31:0] pc);
        ifc.stallreq_id_i = id;
        ifc.stallreq_ex_i = ex;
        ifc.mc_start_i    = st;
        ifc.mc_cycles_i   = CNT_W'(n);
        ifc.flush_req_i   = fr;
        ifc.flush_pc_i    = pc;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 32'h0);
    endtask

    // One clock: check outputs at the falling edge, then advance the model over the rising edge.
    task automatic cycle();
        logic [5:0] exp_stall;
        @(negedge clk);
        if (ifc.flush_req_i || fl_now)
            exp_stall = 6'b000000;
        else if (rem > 0 || ifc.stallreq_ex_i || (ifc.mc_start_i && ifc.mc_cycles_i != 0))
            exp_stall = 6'b001111;
        else if (ifc.stallreq_id_i)
            exp_stall = 6'b000111;
        else
            exp_stall = 6'b000000;
        chk("stall",  32'(ifc.stall_o),   32'(exp_stall));
        chk("flush",  32'(ifc.flush_o),   32'(fl_now));
        chk("new_pc", ifc.new_pc_o,        pc_m);
        chk("busy",   32'(ifc.mc_busy_o), 32'(rem > 0));
        chk("done",   32'(ifc.mc_done_o), 32'(rem == 1));
        obs_stall = ifc.stall_o;
        obs_done  = ifc.mc_done_o;
        obs_flush = ifc.flush_o;
        obs_pc    = ifc.new_pc_o;
        @(posedge clk);
        if (ifc.flush_req_i) begin
            rem    = 0;
            fl_now = 1'b1;
            pc_m   = ifc.flush_pc_i;
        end else if (fl_now) begin
            fl_now = 1'b0;
        end else if (rem > 0) begin
            rem = rem - 1;
        end else if (ifc.mc_start_i && ifc.mc_cycles_i != 0) begin
            rem = int'(ifc.mc_cycles_i);
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(ifc.stall_o),   32'h0);
        chk({tag, "_flush"}, 32'(ifc.flush_o),   32'h0);
        chk({tag, "_pc"},    ifc.new_pc_o,        32'h0);
        chk({tag, "_busy"},  32'(ifc.mc_busy_o), 32'h0);
        chk({tag, "_done"},  32'(ifc.mc_done_o), 32'h0);
    endtask

    initial begin
        int ex_cnt;
        int done_cnt;
        int fl_cnt;

        idle_in();
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycle();

        // Reset during MC_WAIT with count 5
        set_in(0, 0, 1, 6, 0, 32'h0);
        cycle();
        idle_in();
        chk("mid_busy", 32'(ifc.mc_busy_o), 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        rem = 0; fl_now = 1'b0; pc_m = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        cycle();

        // ID stall for two cycles, then combined ID+EX
        set_in(1, 0, 0, 0, 0, 32'h0);
        cycle(); chk("id_stall1", 32'(obs_stall), 32'h07);
        cycle(); chk("id_stall2", 32'(obs_stall), 32'h07);
        set_in(1, 1, 0, 0, 0, 32'h0);
        cycle(); chk("id_ex", 32'(obs_stall), 32'h0f);
        idle_in();
        cycle(); chk("id_release", 32'(obs_stall), 32'h00);

        // Multi-cycle N=3: four stall cycles, done in the fourth
        ex_cnt = 0; done_cnt = 0;
        set_in(0, 0, 1, 3, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            idle_in();
            if (obs_stall == 6'b001111) ex_cnt++;
            if (obs_done) begin
                done_cnt++;
                chk("mc3_done_at", 32'(i), 32'd3);
            end
        end
        chk("mc3_stall_cycles", 32'(ex_cnt), 32'd4);
        chk("mc3_done_pulses",  32'(done_cnt), 32'd1);

        // N=0: no stall, no MC_WAIT
        set_in(0, 0, 1, 0, 0, 32'h0);
        cycle(); chk("n0_stall", 32'(obs_stall), 32'h00);
        idle_in();
        cycle(); chk("n0_busy", 32'(ifc.mc_busy_o), 32'h0);

        // N=63: 64 stall cycles, counter must not wrap
        ex_cnt = 0;
        set_in(0, 0, 1, 63, 0, 32'h0);
        for (int i = 0; i < 70; i++) begin
            cycle();
            idle_in();
            if (obs_stall == 6'b001111) ex_cnt++;
        end
        chk("n63_stall_cycles", 32'(ex_cnt), 32'd64);

        // Flush in the second MC_WAIT cycle aborts the op
        done_cnt = 0;
        set_in(0, 0, 1, 3, 0, 32'h0);
        cycle();
        idle_in();
        cycle();
        set_in(0, 1, 0, 0, 1, 32'h0000_0180);
        cycle(); chk("abort_stall", 32'(obs_stall), 32'h00);
        idle_in();
        cycle();
        chk("abort_flush", 32'(obs_flush), 32'h1);
        chk("abort_pc",    obs_pc, 32'h180);
        for (int i = 0; i < 4; i++) begin
            if (obs_done) done_cnt++;
            cycle();
        end
        chk("abort_no_done", 32'(done_cnt), 32'h0);

        // Back-to-back flushes
        fl_cnt = 0;
        set_in(0, 0, 0, 0, 1, 32'h0000_0100);
        cycle();
        set_in(0, 0, 0, 0, 1, 32'h0000_0200);
        cycle();
        chk("bb_flush1", 32'(obs_flush), 32'h1);
        chk("bb_pc1",    obs_pc, 32'h100);
        idle_in();
        cycle();
        chk("bb_flush2", 32'(obs_flush), 32'h1);
        chk("bb_pc2",    obs_pc, 32'h200);
        cycle();
        chk("bb_flush_end", 32'(obs_flush), 32'h0);

        // Flush on the same cycle as mc_start drops the op
        set_in(0, 0, 1, 5, 1, 32'h0000_0040);
        cycle();
        idle_in();
        cycle();
        cycle();
        chk("drop_busy", 32'(ifc.mc_busy_o), 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bit st;
            int n;
            st = (rem == 0) && !fl_now && ($urandom_range(0, 5) == 0);
            n  = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 4));
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, st, n,
                   $urandom_range(0, 24) == 0, {$urandom_range(0, 32'h3fff_ffff), 2'b00});
            cycle();
        end
        idle_in();
        for (int i = 0; i < 70; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
